// File: rtl/iter_shift_unit.sv
// Multi-cycle shift/rotate unit: moves the operand at most STEP bits per cycle
// and reports completion with a start/busy/done handshake.
module iter_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STEP    = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   dout
);

  // Handshake: start is taken only while busy is low (IDLE). Once taken, busy
  // stays high until the cycle after done; done pulses for one cycle with
  // dout already holding the result. flush aborts without a done pulse.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_e;

  localparam logic [SHAMT_W:0] STEP_C = (SHAMT_W + 1)'(STEP);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     work_q, work_d;
  logic [WIDTH-1:0]     dout_q, dout_d;
  logic [SHAMT_W-1:0]   rem_q, rem_d;
  logic [1:0]           op_q, op_d;

  logic [SHAMT_W-1:0]   step_k;
  logic [SHAMT_W-1:0]   rem_next;
  logic [WIDTH-1:0]     shifted;
  logic [2*WIDTH-1:0]   rot_dbl;

  // One step moves min(rem, STEP) bits; SRA keeps the MSB, which is the
  // captured sign bit because an arithmetic right shift never changes it.
  always_comb begin
    step_k   = ({1'b0, rem_q} < STEP_C) ? rem_q : STEP_C[SHAMT_W-1:0];
    rem_next = rem_q - step_k;
    rot_dbl  = {work_q, work_q} >> step_k;
    shifted  = work_q;
    case (op_q)
      2'b00:   shifted = work_q << step_k;
      2'b01:   shifted = work_q >> step_k;
      2'b10:   shifted = $unsigned($signed(work_q) >>> step_k);
      default: shifted = rot_dbl[WIDTH-1:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    dout_d  = dout_q;
    rem_d   = rem_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d = din;
          op_d   = op;
          rem_d  = shamt;
          if (shamt == '0) begin
            state_d = FIN;
            dout_d  = din;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d = shifted;
        rem_d  = rem_next;
        if (rem_next == '0) begin
          state_d = FIN;
          dout_d  = shifted;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // dout is loaded on the edge into FIN, so a flush before FIN leaves it untouched.
    if (flush) begin
      state_d = IDLE;
      dout_d  = dout_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      work_q  <= '0;
      dout_q  <= '0;
      rem_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      dout_q  <= dout_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == FIN);
  assign dout = dout_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed bench for iter_shift_unit plus a small parameter sweep of
// WIDTH=16/32 and STEP=1/3/WIDTH instances checked against a reference shift.
module tb_iter_shift_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- main DUT (WIDTH=32, STEP=4) ----------------
  logic        start, flush, busy, done;
  logic [1:0]  op;
  logic [31:0] din, dout;
  logic [4:0]  shamt;

  iter_shift_unit #(.WIDTH(32), .STEP(4)) u_dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .din(din),
    .shamt(shamt), .flush(flush), .busy(busy), .done(done), .dout(dout)
  );

  // ---------------- sweep DUTs ----------------
  logic        sw_start;
  logic        sw_flush;
  logic [1:0]  sw_op;
  logic [31:0] sw_din32;
  logic [4:0]  sw_shamt32;
  logic [15:0] sw_din16;
  logic [3:0]  sw_shamt16;
  logic        sw_busy[6];
  logic        sw_done[6];
  logic [31:0] sw_dout32[3];
  logic [15:0] sw_dout16[3];
  int          sw_step[6] = '{1, 3, 32, 1, 3, 16};
  int          sw_lat[6];

  iter_shift_unit #(.WIDTH(32), .STEP(1)) u_w32_s1 (
    .clk(clk), .resetn(resetn), .start(sw_start), .op(sw_op), .din(sw_din32),
    .shamt(sw_shamt32), .flush(sw_flush), .busy(sw_busy[0]), .done(sw_done[0]), .dout(sw_dout32[0])
  );
  iter_shift_unit #(.WIDTH(32), .STEP(3)) u_w32_s3 (
    .clk(clk), .resetn(resetn), .start(sw_start), .op(sw_op), .din(sw_din32),
    .shamt(sw_shamt32), .flush(sw_flush), .busy(sw_busy[1]), .done(sw_done[1]), .dout(sw_dout32[1])
  );
  iter_shift_unit #(.WIDTH(32), .STEP(32)) u_w32_s32 (
    .clk(clk), .resetn(resetn), .start(sw_start), .op(sw_op), .din(sw_din32),
    .shamt(sw_shamt32), .flush(sw_flush), .busy(sw_busy[2]), .done(sw_done[2]), .dout(sw_dout32[2])
  );
  iter_shift_unit #(.WIDTH(16), .STEP(1)) u_w16_s1 (
    .clk(clk), .resetn(resetn), .start(sw_start), .op(sw_op), .din(sw_din16),
    .shamt(sw_shamt16), .flush(sw_flush), .busy(sw_busy[3]), .done(sw_done[3]), .dout(sw_dout16[0])
  );
  iter_shift_unit #(.WIDTH(16), .STEP(3)) u_w16_s3 (
    .clk(clk), .resetn(resetn), .start(sw_start), .op(sw_op), .din(sw_din16),
    .shamt(sw_shamt16), .flush(sw_flush), .busy(sw_busy[4]), .done(sw_done[4]), .dout(sw_dout16[1])
  );
  iter_shift_unit #(.WIDTH(16), .STEP(16)) u_w16_s16 (
    .clk(clk), .resetn(resetn), .start(sw_start), .op(sw_op), .din(sw_din16),
    .shamt(sw_shamt16), .flush(sw_flush), .busy(sw_busy[5]), .done(sw_done[5]), .dout(sw_dout16[2])
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref32(input logic [1:0] o, input logic [31:0] d, input int s);
    case (o)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return 32'($signed(d) >>> s);
      default: return (s == 0) ? d : ((d >> s) | (d << (32 - s)));
    endcase
  endfunction

  function automatic logic [15:0] ref16(input logic [1:0] o, input logic [15:0] d, input int s);
    case (o)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return 16'($signed(d) >>> s);
      default: return (s == 0) ? d : ((d >> s) | (d << (16 - s)));
    endcase
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Issues one operation on the main DUT and checks busy, latency, dout and hold.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] d,
                        input logic [4:0] s, input logic [31:0] exp);
    int lat;
    int exp_lat;
    exp_lat = (int'(s) + 3) / 4;
    @(negedge clk);
    start = 1'b1; op = o; din = d; shamt = s;
    @(posedge clk); #1;
    start = 1'b0; din = $urandom; op = ~o; shamt = ~s;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_dout"}, dout, exp);
    @(posedge clk); #1;
    chk({tag, "_done_low"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_hold"}, dout, exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int ndone;
    resetn = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; din = '0; shamt = '0;
    sw_start = 1'b0; sw_flush = 1'b0; sw_op = 2'b00;
    sw_din32 = '0; sw_shamt32 = '0; sw_din16 = '0; sw_shamt16 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dout", dout, 32'd0);
    @(negedge clk); resetn = 1'b1;

    run_op("sll_1_2",    2'b00, 32'h0000_0001, 5'd2,  32'h0000_0004);
    run_op("sll_branch", 2'b00, 32'h3FFF_FFFF, 5'd2,  32'hFFFF_FFFC);
    run_op("sra_31",     2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    run_op("srl_31",     2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001);
    run_op("rotr_8",     2'b11, 32'h1234_5678, 5'd8,  32'h7812_3456);
    run_op("shamt0",     2'b10, 32'hCAFE_BABE, 5'd0,  32'hCAFE_BABE);
    run_op("rotr_odd",   2'b11, 32'h0000_00F1, 5'd5,  32'h8800_0007);

    // start pulsed again right after acceptance must be ignored
    @(negedge clk);
    start = 1'b1; op = 2'b00; din = 32'h0000_0003; shamt = 5'd13;
    @(posedge clk); #1;
    start = 1'b1; op = 2'b11; din = 32'hFFFF_0000; shamt = 5'd1;
    chk("busy_ign_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("busy_ign_lat", 32'(lat), 32'd4);
    chk("busy_ign_dout", dout, 32'h0000_6000);
    ndone = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("busy_ign_extra_done", 32'(ndone), 32'd0);
    chk("busy_ign_idle", 32'(busy), 32'd0);

    // flush mid-SHIFT: no done, dout keeps its previous value
    @(negedge clk);
    start = 1'b1; op = 2'b00; din = 32'h0000_0001; shamt = 5'd20;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    chk("flush_pre_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_done", 32'(done), 32'd0);
    ndone = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("flush_no_done", 32'(ndone), 32'd0);
    chk("flush_dout", dout, 32'h0000_6000);

    // flush together with start in IDLE drops the start
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b00; din = 32'h0000_AAAA; shamt = 5'd0;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", 32'(busy), 32'd0);
    chk("flush_start_done", 32'(done), 32'd0);
    chk("flush_start_dout", dout, 32'h0000_6000);

    // flush in FIN: done still pulses and dout is updated
    @(negedge clk);
    start = 1'b1; op = 2'b00; din = 32'h0000_0055; shamt = 5'd0;
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b1;
    chk("flush_fin_done", 32'(done), 32'd1);
    chk("flush_fin_dout", dout, 32'h0000_0055);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_fin_idle", 32'(busy), 32'd0);
    chk("flush_fin_done_low", 32'(done), 32'd0);

    // asynchronous reset in the middle of SHIFT
    @(negedge clk);
    start = 1'b1; op = 2'b01; din = 32'hFFFF_FFFF; shamt = 5'd31;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    chk("areset_pre_busy", 32'(busy), 32'd1);
    resetn = 1'b0;
    #1;
    chk("areset_busy", 32'(busy), 32'd0);
    chk("areset_done", 32'(done), 32'd0);
    chk("areset_dout", dout, 32'd0);
    @(negedge clk); resetn = 1'b1;

    // parameter sweep against the reference model
    for (int it = 0; it < 16; it++) begin
      @(negedge clk);
      sw_op      = 2'($urandom_range(0, 3));
      sw_din32   = $urandom;
      sw_shamt32 = 5'($urandom_range(0, 31));
      sw_din16   = 16'($urandom);
      sw_shamt16 = 4'($urandom_range(0, 15));
      if (it == 0) begin
        sw_shamt32 = 5'd31; sw_shamt16 = 4'd15;
      end
      if (it == 1) begin
        sw_shamt32 = 5'd0; sw_shamt16 = 4'd0;
      end
      sw_start = 1'b1;
      @(posedge clk); #1;
      sw_start = 1'b0;
      for (int j = 0; j < 6; j++) sw_lat[j] = -1;
      for (int c = 0; c < 40; c++) begin
        for (int j = 0; j < 6; j++)
          if (sw_done[j] && sw_lat[j] < 0) sw_lat[j] = c;
        @(posedge clk); #1;
      end
      for (int j = 0; j < 3; j++) begin
        chk($sformatf("sw32_s%0d_lat", sw_step[j]), 32'(sw_lat[j]),
            32'((int'(sw_shamt32) + sw_step[j] - 1) / sw_step[j]));
        chk($sformatf("sw32_s%0d_dout_op%0d", sw_step[j], sw_op), sw_dout32[j],
            ref32(sw_op, sw_din32, int'(sw_shamt32)));
      end
      for (int j = 3; j < 6; j++) begin
        chk($sformatf("sw16_s%0d_lat", sw_step[j]), 32'(sw_lat[j]),
            32'((int'(sw_shamt16) + sw_step[j] - 1) / sw_step[j]));
        chk($sformatf("sw16_s%0d_dout_op%0d", sw_step[j], sw_op), {16'd0, sw_dout16[j-3]},
            {16'd0, ref16(sw_op, sw_din16, int'(sw_shamt16))});
      end
    end

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
